// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S slave receiver: Philips-format deserialiser with valid/ready pair output
// SCLK/WS/SD are synchronised with equal latency; words are MSB-justified into WORD_W.
module i2s_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_enable,
    input  logic              i_sclk,
    input  logic              i_ws,
    input  logic              i_sd,
    input  logic              i_ready,
    input  logic              i_ovr_clr,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data_left,
    output logic [WORD_W-1:0] o_data_right,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int CW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t               state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, ws_sync, sd_sync;
    logic                 sclk_s, ws_s, sd_s, sclk_d;
    logic                 sclk_rise, word_change;
    logic                 ws_prev;
    logic [CW-1:0]        bit_cntr;
    logic [WORD_W-1:0]    shift_reg, word_next, left_hold, right_word;
    logic                 pair_pend, ovr_set;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ws_s        = ws_sync[SYNC_STAGES-1];
    assign sd_s        = sd_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign word_change = ws_s != ws_prev;
    assign o_busy      = state == RUN;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sclk_sync <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
            sclk_d    <= 1'b0;
            ws_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], i_ws};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i_sd};
            sclk_d    <= sclk_s;
            if (sclk_rise) ws_prev <= ws_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_enable) state_next = SYNC;
            SYNC:    if (sclk_rise && word_change && !ws_s) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!i_enable) state_next = IDLE;
    end

    // Bits past WORD_W match no position and are dropped.
    always_comb begin
        word_next = shift_reg;
        for (int i = 0; i < WORD_W; i++) begin
            if (int'(bit_cntr) == WORD_W - 1 - i) word_next[i] = sd_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            shift_reg  <= '0;
            bit_cntr   <= '0;
            left_hold  <= '0;
            right_word <= '0;
            pair_pend  <= 1'b0;
        end else begin
            pair_pend <= 1'b0;
            if (state == IDLE) begin
                shift_reg <= '0;
                bit_cntr  <= '0;
            end else if (sclk_rise) begin
                if (word_change) begin
                    shift_reg <= '0;
                    bit_cntr  <= '0;
                    if (state == RUN && i_enable) begin
                        if (!ws_prev) begin
                            left_hold <= word_next;
                        end else begin
                            right_word <= word_next;
                            pair_pend  <= 1'b1;
                        end
                    end
                end else begin
                    shift_reg <= word_next;
                    if (bit_cntr != CW'(WORD_W)) bit_cntr <= bit_cntr + 1'b1;
                end
            end
        end
    end

    // A pending pair is lost only if the previous one is still held and not taken this cycle.
    assign ovr_set = (state != IDLE) && pair_pend && o_valid && !i_ready;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_valid      <= 1'b0;
            o_data_left  <= '0;
            o_data_right <= '0;
            o_overrun    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                o_valid <= 1'b0;
            end else if (pair_pend && !ovr_set) begin
                o_valid      <= 1'b1;
                o_data_left  <= left_hold;
                o_data_right <= right_word;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (ovr_set)        o_overrun <= 1'b1;
            else if (i_ovr_clr) o_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed self-checking bench for i2s_rx
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        nrst, enable, sclk, ws, sd, ready, ovr_clr;
    logic        valid, overrun, busy;
    logic [31:0] data_left, data_right;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    i2s_rx #(.SYNC_STAGES(2), .WORD_W(32)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_enable(enable), .i_sclk(sclk), .i_ws(ws),
        .i_sd(sd), .i_ready(ready), .i_ovr_clr(ovr_clr), .o_valid(valid),
        .o_data_left(data_left), .o_data_right(data_right), .o_overrun(overrun),
        .o_busy(busy)
    );

    // SCLK period 80 ns against a 10 ns i_clk keeps the 8x ratio.
    task send_bit(input logic w, input logic d);
        ws = w; sd = d;
        #40 sclk = 1'b1;
        #40 sclk = 1'b0;
    endtask

    // The last bit of a word carries the next word's WS (Philips one-bit delay).
    task send_bits(input logic ch, input logic [63:0] data, input int hi, input int lo, input logic next_ch);
        for (int i = hi; i >= lo; i--) send_bit((i == 0) ? next_ch : ch, data[i]);
    endtask

    task send_frame(input logic [63:0] l, input logic [63:0] r, input int n);
        send_bits(1'b0, l, n - 1, 0, 1'b1);
        send_bits(1'b1, r, n - 1, 0, 1'b0);
    endtask

    task check_pair(input string name, input logic [31:0] l, input logic [31:0] r);
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL %s valid: got %b want 1", name, valid); end
        checks++;
        if (data_left !== l) begin errors++; $display("FAIL %s left: got %h want %h", name, data_left, l); end
        checks++;
        if (data_right !== r) begin errors++; $display("FAIL %s right: got %h want %h", name, data_right, r); end
    endtask

    task accept(input string name);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL %s accept: valid got %b want 0", name, valid); end
    endtask

    task test_reset;
        nrst = 1'b0; enable = 1'b0; sclk = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b0; ovr_clr = 1'b0;
        #20 nrst = 1'b1;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", valid); end
        checks++; if (data_left !== 32'h0) begin errors++; $display("FAIL reset left: got %h want 0", data_left); end
        checks++; if (data_right !== 32'h0) begin errors++; $display("FAIL reset right: got %h want 0", data_right); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    endtask

    task test_32bit;
        logic [63:0] r;
        int lat;
        r = 64'h1234_5678;
        lat = 0;
        enable = 1'b1;
        @(negedge clk);
        send_bits(1'b1, 64'h0, 7, 0, 1'b0);
        send_bits(1'b0, 64'hA5A5_0F0F, 31, 0, 1'b1);
        send_bits(1'b1, r, 31, 1, 1'b0);
        ws = 1'b0; sd = r[0];
        #40 sclk = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) begin lat = k; break; end
        end
        @(negedge clk) sclk = 1'b0;
        #40;
        checks++; if (lat != 4) begin errors++; $display("FAIL w32 latency: got %0d want 4", lat); end
        check_pair("w32", 32'hA5A5_0F0F, 32'h1234_5678);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL w32 overrun: got %b want 0", overrun); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL w32 busy: got %b want 1", busy); end
        accept("w32");
    endtask

    task test_short_slot;
        send_frame(64'hBEEF, 64'h0001, 16);
        check_pair("w16", 32'hBEEF_0000, 32'h0001_0000);
        accept("w16");
    endtask

    task test_long_slot;
        send_frame(64'hDEAD_BEEF_CAFE, 64'h0, 48);
        check_pair("w48", 32'hDEAD_BEEF, 32'h0);
        accept("w48");
    endtask

    task test_overrun;
        send_frame(64'h1111_1111, 64'h2222_2222, 32);
        check_pair("ovr f1", 32'h1111_1111, 32'h2222_2222);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr f1 overrun: got %b want 0", overrun); end
        send_frame(64'h3333_3333, 64'h4444_4444, 32);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr f2 overrun: got %b want 1", overrun); end
        send_frame(64'h5555_5555, 64'h6666_6666, 32);
        check_pair("ovr f3", 32'h1111_1111, 32'h2222_2222);
        accept("ovr");
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr sticky: got %b want 1", overrun); end
        @(negedge clk) ovr_clr = 1'b1;
        @(negedge clk) ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr clear: got %b want 0", overrun); end
        send_frame(64'h7777_7777, 64'h8888_8888, 32);
        check_pair("ovr f4", 32'h7777_7777, 32'h8888_8888);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr f4 overrun: got %b want 0", overrun); end
        accept("ovr f4");
    endtask

    task test_mid_enable;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL men idle busy: got %b want 0", busy); end
        send_bits(1'b0, 64'h9999_9999, 31, 22, 1'b1);
        enable = 1'b1;
        send_bits(1'b0, 64'h9999_9999, 21, 0, 1'b1);
        send_bits(1'b1, 64'hAAAA_AAAA, 31, 0, 1'b0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL men partial valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL men run busy: got %b want 1", busy); end
        send_frame(64'h0BAD_F00D, 64'hC0DE_0042, 32);
        check_pair("men", 32'h0BAD_F00D, 32'hC0DE_0042);
        accept("men");
    endtask

    task test_disable_mid_right;
        send_bits(1'b0, 64'hCCCC_CCCC, 31, 0, 1'b1);
        send_bits(1'b1, 64'hDDDD_DDDD, 31, 16, 1'b1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis busy: got %b want 0", busy); end
        enable = 1'b1;
        @(negedge clk);
        send_bits(1'b1, 64'hDDDD_DDDD, 15, 0, 1'b0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL dis broken valid: got %b want 0", valid); end
        send_frame(64'h0123_4567, 64'h89AB_CDEF, 32);
        check_pair("dis", 32'h0123_4567, 32'h89AB_CDEF);
        accept("dis");
    endtask

    initial begin
        test_reset;
        test_32bit;
        test_short_slot;
        test_long_slot;
        test_overrun;
        test_mid_enable;
        test_disable_mid_right;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S slave receiver for the APB I2S peripheral.
- Samples an external serial data line using externally supplied SCLK and WS. Both are treated as asynchronous to i_clk.
- Deserialises Philips-format frames (one-bit delay after the WS edge) into 32-bit left/right word pairs.
- Presents each completed pair to the APB register/FIFO side over a valid/ready handshake and flags overruns.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchroniser (minimum 2).
- WORD_W, 32, output word width. Received bits are MSB-justified into this width.

Ports:
- i_clk  in  1  system clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_enable  in  1  receiver enable
- i_sclk  in  1  I2S bit clock, asynchronous to i_clk
- i_ws  in  1  I2S word select: 0 = left, 1 = right
- i_sd  in  1  I2S serial data
- i_ready  in  1  consumer accepts the current pair
- i_ovr_clr  in  1  single-cycle clear of o_overrun
- o_valid  out  1  a word pair is available
- o_data_left  out  WORD_W  left word
- o_data_right  out  WORD_W  right word
- o_overrun  out  1  sticky: a pair was lost
- o_busy  out  1  high when in RUN state

Behaviour:
- Reset values: all outputs 0, state IDLE, shift register 0, bit counter 0, ws_prev 0.
- Synchronisers: i_sclk, i_ws and i_sd each pass through SYNC_STAGES flops, so all three carry equal latency.
- SCLK rising-edge detect: synced SCLK is 1 and its registered copy is 0. This yields a one-i_clk strobe sclk_rise.
- Clock ratio: i_clk ≥ 8× SCLK is required. Behaviour below that ratio is undefined.
- Sampling: on sclk_rise, capture sd_s and ws_s together. ws_prev updates to ws_s on every sclk_rise.
- Word change: a sclk_rise with ws_s != ws_prev is a word change. The bit sampled at that edge is the LSB slot of the outgoing word (ws_prev channel). Every later bit belongs to the new word.
- Bit placement: bit_cntr runs 0..WORD_W and saturates at WORD_W. Each sampled bit is written to shift_reg[WORD_W-1-bit_cntr] while bit_cntr < WORD_W.
  - Slot longer than WORD_W: excess bits are dropped.
  - Slot shorter than WORD_W: the unwritten LSBs stay 0.
- Word complete: after writing the word-change bit, the word is complete.
  - shift_reg is cleared and bit_cntr reset to 0 for the next word.
  - The completed word goes to left_hold when ws_prev=0. When ws_prev=1 it completes the pair.
- State machine:
  - IDLE: i_enable=0. Shift register and counter are held at 0. o_valid is forced to 0. o_data_* keep their last values. Enabling moves to SYNC.
  - SYNC: samples are tracked but no words are stored. The first word change with ws_s=0 (right→left boundary) moves to RUN. The partial frame is discarded.
  - RUN: normal reception. i_enable=0 in any state returns to IDLE on the next cycle and abandons the partial frame.
- Pair output: the cycle after a right-word completion in RUN, the outputs update.
  - o_data_left ← left_hold; o_data_right ← completed right word.
  - o_valid ← 1.
- Handshake: o_valid stays high until a cycle with o_valid && i_ready; it drops the following cycle. Data is stable while o_valid=1.
- Overrun: a new pair completes while o_valid=1 and i_ready=0 in the same cycle.
  - The new pair is dropped and the old data is kept.
  - o_overrun ← 1.
- Completion and acceptance in the same cycle: if a pair completes in the same cycle as acceptance, it loads with no overrun.
- o_overrun clear: cleared by i_ovr_clr. If set and clear coincide, set wins. o_overrun is not cleared by disable.
- Latency: from the SCLK rising edge carrying the right-channel word-change bit to o_valid is SYNC_STAGES+2 i_clk cycles.
- Reset asserted mid-frame: immediate return to reset values. The first pair after release needs the SYNC boundary again.

Test Plan:
- 32-bit slots, enable before the frame: left 0xA5A5_0F0F, right 0x1234_5678 → one o_valid with exactly these values, asserted SYNC_STAGES+2 cycles after the right LSB edge; o_overrun=0.
- 16-bit slots: left 0xBEEF, right 0x0001 → o_data_left=0xBEEF_0000, o_data_right=0x0001_0000.
- 48-bit slots: left 0xDEADBEEF_CAFE, right 0x0 → o_data_left=0xDEADBEEF (excess bits dropped).
- i_ready held 0 across three frames with distinct data → o_valid stays 1 with frame-1 data and o_overrun=1. Then i_ready pulse → o_valid falls. Then i_ovr_clr → o_overrun=0; the fourth frame is delivered.
- Enable asserted mid-left-word → first partial frame discarded; the first o_valid carries the second full frame.
- Disable mid-right-word, re-enable → no o_valid for the broken frame; the next complete frame after the right→left boundary is delivered correctly.
